req_queue: RTL

Request front end for the two-requester arbiter. Buffers each requester's transactions in a small per-channel FIFO and drives `req_0`/`req_1` from FIFO occupancy. It consumes `gnt_0`/`gnt_1` to pop the granted head onto a single shared output. It sits directly upstream of the arbiter and closes the loop on its grants.

---
 rtl/req_queue_pkg.sv | 12 +
 rtl/req_queue_if.sv | 34 +++
 rtl/req_queue_fifo.sv | 53 +++++
 rtl/req_queue.sv | 75 +++++++
 4 files changed

// File: rtl/req_queue_pkg.sv
// Shared defaults and types for the two-channel request front end.
package req_queue_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 4;

  typedef enum logic {
    SRC0 = 1'b0,
    SRC1 = 1'b1
  } src_e;

endpackage

// File: rtl/req_queue_if.sv
// Handshake, arbiter and output signals of req_queue, bundled for port connection.
interface req_queue_if
  import req_queue_pkg::*;
#(
  parameter int unsigned DATA_W = req_queue_pkg::DATA_W
) ();

  logic              in0_valid;
  logic              in0_ready;
  logic [DATA_W-1:0] in0_data;
  logic              in1_valid;
  logic              in1_ready;
  logic [DATA_W-1:0] in1_data;
  logic              req_0;
  logic              req_1;
  logic              gnt_0;
  logic              gnt_1;
  logic              out_valid;
  src_e              out_src;
  logic [DATA_W-1:0] out_data;
  logic              err_gnt;

  // master: producers, arbiter and consumer around the queue
  modport master (
    output in0_valid, in0_data, in1_valid, in1_data, gnt_0, gnt_1,
    input  in0_ready, in1_ready, req_0, req_1, out_valid, out_src, out_data, err_gnt
  );

  modport slave (
    input  in0_valid, in0_data, in1_valid, in1_data, gnt_0, gnt_1,
    output in0_ready, in1_ready, req_0, req_1, out_valid, out_src, out_data, err_gnt
  );

endinterface

// File: rtl/req_queue_fifo.sv
// Per-channel synchronous FIFO; full/empty come from the registered occupancy count.
module req_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/req_queue.sv
// Two-channel request front end: buffers each channel, raises requests, pops on grant.
module req_queue
  import req_queue_pkg::*;
#(
  parameter int unsigned DATA_W = req_queue_pkg::DATA_W,
  parameter int unsigned DEPTH  = req_queue_pkg::DEPTH
) (
  input logic        clk,
  input logic        rst,
  req_queue_if.slave bus
);

  logic              full_0, full_1;
  logic              empty_0, empty_1;
  logic [DATA_W-1:0] head_0, head_1;
  logic              pop_0, pop_1;
  logic              bad_gnt;

  req_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_0 (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.in0_valid),
    .push_data (bus.in0_data),
    .pop       (pop_0),
    .head      (head_0),
    .full      (full_0),
    .empty     (empty_0)
  );

  req_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_1 (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.in1_valid),
    .push_data (bus.in1_data),
    .pop       (pop_1),
    .head      (head_1),
    .full      (full_1),
    .empty     (empty_1)
  );

  assign bus.in0_ready = !full_0;
  assign bus.in1_ready = !full_1;
  assign bus.req_0     = !empty_0;
  assign bus.req_1     = !empty_1;

  // A dual grant pops nothing; a grant to an empty channel is flagged, not executed.
  always_comb begin
    pop_0   = bus.gnt_0 && !bus.gnt_1 && !empty_0;
    pop_1   = bus.gnt_1 && !bus.gnt_0 && !empty_1;
    bad_gnt = (bus.gnt_0 && bus.gnt_1) || (bus.gnt_0 && empty_0) || (bus.gnt_1 && empty_1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.out_valid <= 1'b0;
      bus.out_src   <= SRC0;
      bus.out_data  <= '0;
    end else begin
      bus.out_valid <= pop_0 || pop_1;
      if (pop_0) begin
        bus.out_src  <= SRC0;
        bus.out_data <= head_0;
      end else if (pop_1) begin
        bus.out_src  <= SRC1;
        bus.out_data <= head_1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         bus.err_gnt <= 1'b0;
    else if (bad_gnt) bus.err_gnt <= 1'b1;
  end

endmodule
